// File: rtl/breg_arb.sv
`ifndef BITNESS
`define BITNESS 8
`endif

`default_nettype none

// ============================================================================
// Module   : breg_arb
// Brief    : Round-robin arbiter that lets NREQ requesters share one
//            register-file port pair.  A granted write goes out on the
//            register-file write port in the grant cycle.  A granted read
//            drives the register-file read address in the grant cycle.  The
//            returned word is held in a per-requester response slot until
//            the requester takes it.
// Revision : 1.0  initial release
// ============================================================================
module breg_arb #(
    parameter int NREQ = 3,
    parameter int W    = `BITNESS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ-1:0]   req_y,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [W*NREQ-1:0] req_wdata,
    input  logic [W*NREQ-1:0] req_mask,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W*NREQ-1:0] rsp_data,
    output logic [3:0]        br_ra,
    input  logic [W-1:0]      br_rval,
    output logic              br_w,
    output logic              br_y,
    output logic [3:0]        br_wa,
    output logic [W-1:0]      br_wval,
    output logic [W-1:0]      br_mask
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Round-robin search start; the requester just served moves to the back.
    logic [c_PTR_W-1:0] r_ptr;

    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_grant;
    logic               w_any;
    logic               w_gnt_any;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W-1:0] w_idx;

    logic               w_sel_wr;
    logic               w_sel_y;
    logic [3:0]         w_sel_addr;
    logic [W-1:0]       w_sel_wdata;
    logic [W-1:0]       w_sel_mask;
    logic               w_gnt_wr;
    logic               w_gnt_rd;

    // Index arithmetic modulo NREQ; NREQ need not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_wrap(input int s);
        int t;
        t = s;
        if (t >= NREQ) begin
            t = t - NREQ;
        end
        return c_PTR_W'(t);
    endfunction

    // A requester with an untaken response must not issue anything else,
    // so its response slot can never be overwritten.
    assign w_elig = req_valid & ~rsp_valid;

    // Round-robin pick: walk the search order backwards so that the first
    // eligible requester at or after r_ptr is the last one written.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = f_wrap(int'(r_ptr) + k);
            if (w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Reset masks every grant so nothing is issued while rst is high,
    // including a write caught in the cycle reset arrives.
    assign w_gnt_any = w_any & ~rst;
    assign w_grant   = w_gnt_any ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
    assign req_ready = w_grant;

    // Steer the winning requester's command fields onto one set of wires.
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_y     = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_mask  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_wr    = req_wr[i];
                w_sel_y     = req_y[i];
                w_sel_addr  = req_addr[4*i +: 4];
                w_sel_wdata = req_wdata[W*i +: W];
                w_sel_mask  = req_mask[W*i +: W];
            end
        end
    end

    assign w_gnt_wr = w_gnt_any &  w_sel_wr;
    assign w_gnt_rd = w_gnt_any & ~w_sel_wr;

    // Register-file ports read as all zeros whenever they are not in use.
    assign br_w    = w_gnt_wr;
    assign br_y    = w_gnt_wr & w_sel_y;
    assign br_wa   = w_gnt_wr ? w_sel_addr  : 4'd0;
    assign br_wval = w_gnt_wr ? w_sel_wdata : '0;
    assign br_mask = w_gnt_wr ? w_sel_mask  : '0;
    assign br_ra   = w_gnt_rd ? w_sel_addr  : 4'd0;

    // Advance the search start past the winner; hold it when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            if (w_win == c_PTR_W'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + 1'b1;
            end
        end
    end

    // One response slot per requester.  The register file answers in the
    // grant cycle, so the word is captured on the grant edge.
    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        logic         r_valid;
        logic [W-1:0] r_data;

        // Capture read data on grant; drop the slot once it is taken.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_grant[g] && !req_wr[g]) begin
                r_valid <= 1'b1;
                r_data  <= br_rval;
            end else if (r_valid && rsp_ready[g]) begin
                r_valid <= 1'b0;
            end
        end

        assign rsp_valid[g]        = r_valid;
        assign rsp_data[W*g +: W]  = r_data;
    end

endmodule

`default_nettype wire
